uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the UART controller. It samples the asynchronous `rx` line, recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) and presents each byte on `dout` with a one-cycle `d_rdy` strobe. It sits directly upstream of the I/O controller and drives that controller's `din`/`d_rdy` inputs, so echo mode works directly from the serial line.

## Interface
- `CLK_FREQ`, default 100000000: system clock frequency in Hz.
- `BAUD`, default 115200: line bit rate.
- `CPB` (localparam) = CLK_FREQ/BAUD, integer division; clocks per bit (868 at the defaults). Must be ≥ 4.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idle level is 1.
- `dout`  out  8  last correctly received byte.
- `d_rdy`  out  1  one-cycle strobe: `dout` has just been updated.
- `frm_err`  out  1  one-cycle strobe: stop bit sampled as 0.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Synchronizer: `rx` passes through two flip-flops to give `rx_s`. Both flops reset to 1. No logic uses raw `rx`.
- Counters:
  - `bit_ctr` is sized for 0..CPB-1.
  - `idx` is 3 bits and counts data bits.
  - `sh` is an 8-bit shift register; received bits enter at the MSB and shift right.
- States:
  - IDLE
    - `bit_ctr` = 0.
    - `rx_s` = 0 → START.
  - START
    - `bit_ctr` increments each cycle.
    - At `bit_ctr` = CPB/2-1 (integer division), sample `rx_s`:
      - 0 → DATA, with `bit_ctr` = 0 and `idx` = 0.
      - 1 → IDLE. The event is a glitch; no strobe is produced.
  - DATA
    - At `bit_ctr` = CPB-1: `sh` ← {`rx_s`, `sh[7:1]`}, `bit_ctr` ← 0, `idx` increments.
    - After the sample taken at `idx` = 7 → STOP.
  - STOP
    - At `bit_ctr` = CPB-1, sample `rx_s`:
      - 1 → `dout` ← `sh`, `d_rdy` = 1 for that cycle, go to IDLE.
      - 0 → `frm_err` = 1 for that cycle, `dout` is left unchanged, go to WAIT_IDLE.
  - WAIT_IDLE
    - Stay until `rx_s` = 1, then go to IDLE. This covers a break or misframed line, which must not retrigger reception.
- Sampling: every sample falls nominally at mid-bit, because START aligns to the start-bit centre and every later sample is CPB cycles apart.
- No handshake back-pressure: the consumer must take `dout` on the `d_rdy` cycle. `dout` holds its value until the next good frame.
- Reset, including mid-frame: the state returns to IDLE and all counters clear. Any partial byte is discarded; no strobe is produced for it.

## Timing
- Reset values:
  - `dout` = 8'h00; `d_rdy` = 0; `frm_err` = 0; `busy` = 0.
  - Synchronizer flops = 1; state = IDLE.
- Synchronizer latency is 2 cycles. IDLE→START occurs on the first edge at which `rx_s` = 0.
- `d_rdy` rises on the clock edge that is CPB/2 + 9·CPB + 3 cycles (±1) after the first edge at which `rx` is low. The bench accepts a ±2 window.
- `d_rdy` and `frm_err` are registered, never high together, and each lasts exactly 1 cycle.
- Back-to-back frames, where the next start bit follows the stop bit immediately, must be received. Reception returns to IDLE at the centre of the stop bit, leaving half a bit of margin.
- Baud tolerance: the block must decode correctly with a ±2% rate mismatch.
- `rst` has priority over every state transition in the same cycle.

## Test plan
Sim parameters: CLK_FREQ=16, BAUD=1, so CPB=16.

- Single frame 0x55, then 0xA5 driven by a bench UART model → two `d_rdy` pulses, `dout` = 0x55 then 0xA5. Each pulse falls within the latency window (≈155 cycles after the falling edge).
- Back-to-back frames 0x00, 0xFF, 0x3C with zero idle gap → three `d_rdy` pulses exactly 160 cycles apart, with correct `dout` values and `frm_err` never set.
- Glitch: `rx` low for 5 cycles, then high → `busy` pulses, no `d_rdy`, no `frm_err`. `dout` keeps its previous value.
- Bad stop: frame 0x81 with stop bit = 0, line then held low for 40 cycles before returning high, then a valid frame 0x42 →
  - one `frm_err` pulse and `dout` still 0x00;
  - no activity while the line is held low;
  - then `d_rdy` with `dout` = 0x42.
- Reset mid-frame: assert `rst` for 1 cycle during bit 4 of frame 0x99 → all outputs at reset values, no strobe for 0x99. The next frame 0x17 is received correctly.
- Rate skew: drive 0xC3 at 2% fast, then at 2% slow → `dout` = 0xC3 both times, with no `frm_err`.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Serial receiver for 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop
// bit). The asynchronous line is brought into the clock domain through a
// two-flop synchronizer. Every later sample falls nominally at the centre of a
// bit: START waits half a bit to line up with the start-bit centre, and every
// following sample is one full bit period after the previous one.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD       line bit rate; CPB = CLK_FREQ/BAUD clocks per bit (must be >= 4)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   rx         in   asynchronous serial input, idles high
//   dout       out  last correctly received byte
//   d_rdy      out  one-cycle strobe: dout has just been updated
//   frm_err    out  one-cycle strobe: stop bit sampled as 0
//   busy       out  high whenever the receiver is not idle
//   dbg_state  out  current FSM state, for observation only
//
// Handshake: there is no back-pressure. dout is valid on the cycle d_rdy is
// high and holds its value until the next good frame; the consumer must take
// it on that cycle. d_rdy and frm_err are never high together.
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       d_rdy,
   output logic       frm_err,
   output logic       busy,
   output logic [2:0] dbg_state
);

   localparam int CPB   = CLK_FREQ / BAUD;
   localparam int CTR_W = (CPB > 1) ? $clog2(CPB) : 1;

   // Compare points for the bit counter.
   localparam logic [CTR_W-1:0] HALF_M1 = CTR_W'(CPB / 2 - 1);
   localparam logic [CTR_W-1:0] FULL_M1 = CTR_W'(CPB - 1);
   localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4
   } state_t;

   state_t           r_state;
   logic             r_rx_meta;
   logic             r_rx_s;
   logic [CTR_W-1:0] r_bit_ctr;
   logic [2:0]       r_idx;
   logic [7:0]       r_sh;
   logic [7:0]       r_dout;
   logic             r_d_rdy;
   logic             r_frm_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_state   <= S_IDLE;
         r_bit_ctr <= '0;
         r_idx     <= 3'd0;
         r_sh      <= 8'h00;
         r_dout    <= 8'h00;
         r_d_rdy   <= 1'b0;
         r_frm_err <= 1'b0;
      end else begin
         // Two-flop synchronizer; only r_rx_s is used below.
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;

         // Strobes default low so each lasts exactly one cycle.
         r_d_rdy   <= 1'b0;
         r_frm_err <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_bit_ctr <= '0;
               r_idx     <= 3'd0;
               if (!r_rx_s) begin
                  r_state <= S_START;
               end
            end

            S_START: begin
               // Re-check the line at the start-bit centre; a line that is
               // already high again was only a glitch.
               if (r_bit_ctr == HALF_M1) begin
                  r_bit_ctr <= '0;
                  r_idx     <= 3'd0;
                  if (r_rx_s) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_DATA;
                  end
               end else begin
                  r_bit_ctr <= r_bit_ctr + CTR_ONE;
               end
            end

            S_DATA: begin
               if (r_bit_ctr == FULL_M1) begin
                  // LSB arrives first, so bits enter at the top and shift down.
                  r_sh      <= {r_rx_s, r_sh[7:1]};
                  r_bit_ctr <= '0;
                  r_idx     <= r_idx + 3'd1;
                  if (r_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end
               end else begin
                  r_bit_ctr <= r_bit_ctr + CTR_ONE;
               end
            end

            S_STOP: begin
               // Leaving at the stop-bit centre keeps half a bit of margin for
               // a start bit that follows immediately.
               if (r_bit_ctr == FULL_M1) begin
                  r_bit_ctr <= '0;
                  if (r_rx_s) begin
                     r_dout  <= r_sh;
                     r_d_rdy <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_frm_err <= 1'b1;
                     r_state   <= S_WAIT_IDLE;
                  end
               end else begin
                  r_bit_ctr <= r_bit_ctr + CTR_ONE;
               end
            end

            S_WAIT_IDLE: begin
               // A break or misframed line must go high before a new start
               // bit can be recognised.
               r_bit_ctr <= '0;
               r_idx     <= 3'd0;
               if (r_rx_s) begin
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_state   <= S_IDLE;
               r_bit_ctr <= '0;
               r_idx     <= 3'd0;
            end
         endcase
      end
   end

   assign dout      = r_dout;
   assign d_rdy     = r_d_rdy;
   assign frm_err   = r_frm_err;
   assign busy      = (r_state != S_IDLE);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Bench for uart_rx at CLK_FREQ=16, BAUD=1 (16 clocks per bit, 10 ns clock).
// A behavioural UART transmitter drives the line with time delays, and the
// expected bytes are kept in a queue that is compared with what the receiver
// strobes out.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

   localparam real BIT_NS = 160.0;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] dout;
   logic       d_rdy;
   logic       frm_err;
   logic       busy;
   logic [2:0] dbg_state;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   bit busy_seen = 0;
   int last_fall = 0;

   logic [7:0] exp_q[$];
   logic [7:0] rdy_q[$];
   int         rdy_cyc_q[$];

   uart_rx #(
      .CLK_FREQ(16),
      .BAUD    (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .dout     (dout),
      .d_rdy    (d_rdy),
      .frm_err  (frm_err),
      .busy     (busy),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog: the stimulus is a fixed-length sequence, this only guards
   // against a simulator-level hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no end, expected summary");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // ---------------- output monitor ----------------
   always @(negedge clk) begin
      if (d_rdy) begin
         rdy_q.push_back(dout);
         rdy_cyc_q.push_back(cyc);
      end
      if (frm_err) err_cnt++;
      if (d_rdy && frm_err) both_cnt++;
      if (busy) busy_seen = 1'b1;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [9:0] mk_frame(input logic [7:0] b, input logic stop_bit);
      return {stop_bit, b, 1'b0};
   endfunction

   // Drives the first n bits of a frame (start bit first) at the given bit time.
   task automatic drive_bits(input logic [9:0] f, input int n, input real bit_ns);
      for (int i = 0; i < n; i++) begin
         rx = f[i];
         #(bit_ns);
      end
   endtask

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   // Aligned full-length good frame; remembers the cycle of the first edge
   // that sees the line low.
   task automatic send_byte(input logic [7:0] b);
      last_fall = cyc + 1;
      exp_q.push_back(b);
      drive_bits(mk_frame(b, 1'b1), 10, BIT_NS);
   endtask

   task automatic pulse_reset();
      align();
      rst = 1'b1;
      align();
      rst = 1'b0;
   endtask

   // Compares received bytes with the expected queue, then empties both.
   task automatic check_rx(input string tag);
      int n;
      chk({tag, "_count"}, rdy_q.size(), exp_q.size());
      n = (rdy_q.size() < exp_q.size()) ? rdy_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_byte%0d", tag, i), {24'd0, rdy_q[i]}, {24'd0, exp_q[i]});
      end
      rdy_q.delete();
      exp_q.delete();
      rdy_cyc_q.delete();
   endtask

   task automatic check_latency(input string tag);
      int d;
      d = (rdy_cyc_q.size() > 0) ? (rdy_cyc_q[0] - last_fall) : -1;
      chk($sformatf("%s_latency(%0d)", tag, d), {31'd0, (d >= 153 && d <= 157)}, 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int err_base;
      logic [7:0] b;
      int gap;
      real bit_ns;

      rst = 1'b1;
      rx  = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;

      // Reset values.
      chk("reset_dout", {24'd0, dout}, 32'h00);
      chk("reset_d_rdy", {31'd0, d_rdy}, 32'd0);
      chk("reset_frm_err", {31'd0, frm_err}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      repeat (20) @(posedge clk);

      // Single frames 0x55 then 0xA5, with latency from the falling edge.
      align();
      send_byte(8'h55);
      #(BIT_NS * 2);
      check_latency("f55");
      check_rx("f55");
      align();
      send_byte(8'hA5);
      #(BIT_NS * 2);
      check_latency("fA5");
      check_rx("fA5");

      // Back-to-back frames with no idle gap.
      err_base = err_cnt;
      align();
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h3C);
      #(BIT_NS * 2);
      chk("b2b_pulses", rdy_cyc_q.size(), 32'd3);
      if (rdy_cyc_q.size() == 3) begin
         chk("b2b_gap01", rdy_cyc_q[1] - rdy_cyc_q[0], 32'd160);
         chk("b2b_gap12", rdy_cyc_q[2] - rdy_cyc_q[1], 32'd160);
      end
      chk("b2b_no_frm_err", err_cnt - err_base, 32'd0);
      check_rx("b2b");

      // Glitch: line low for 5 cycles only.
      err_base = err_cnt;
      busy_seen = 1'b0;
      align();
      rx = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
      chk("glitch_busy_back", {31'd0, busy}, 32'd0);
      chk("glitch_no_frm_err", err_cnt - err_base, 32'd0);
      chk("glitch_dout_kept", {24'd0, dout}, 32'h3C);
      check_rx("glitch");

      // Bad stop bit from a freshly reset receiver, line held low afterwards.
      pulse_reset();
      repeat (20) @(posedge clk);
      err_base = err_cnt;
      align();
      drive_bits(mk_frame(8'h81, 1'b0), 10, BIT_NS);
      #400;
      chk("badstop_frm_err", err_cnt - err_base, 32'd1);
      chk("badstop_dout", {24'd0, dout}, 32'h00);
      chk("badstop_hold_busy", {31'd0, busy}, 32'd1);
      chk("badstop_no_rdy", rdy_q.size(), 32'd0);
      chk("badstop_strobes_apart", both_cnt, 32'd0);
      rx = 1'b1;
      #(BIT_NS * 2);
      chk("badstop_idle_again", {31'd0, busy}, 32'd0);
      align();
      send_byte(8'h42);
      #(BIT_NS * 2);
      check_rx("after_badstop");
      chk("after_badstop_dout", {24'd0, dout}, 32'h42);

      // Reset in the middle of bit 4 of 0x99; the transmitter abandons the
      // frame and the line goes idle.
      align();
      drive_bits(mk_frame(8'h99, 1'b1), 5, BIT_NS);
      rx = 1'b1;
      #(BIT_NS / 2);
      pulse_reset();
      chk("midrst_dout", {24'd0, dout}, 32'h00);
      chk("midrst_d_rdy", {31'd0, d_rdy}, 32'd0);
      chk("midrst_frm_err", {31'd0, frm_err}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      #(BIT_NS * 8);
      check_rx("midrst_no_strobe");
      align();
      send_byte(8'h17);
      #(BIT_NS * 2);
      check_rx("after_midrst");

      // Rate skew: 2% fast then 2% slow.
      err_base = err_cnt;
      exp_q.push_back(8'hC3);
      drive_bits(mk_frame(8'hC3, 1'b1), 10, BIT_NS * 0.98);
      #(BIT_NS * 2);
      exp_q.push_back(8'hC3);
      drive_bits(mk_frame(8'hC3, 1'b1), 10, BIT_NS * 1.02);
      #(BIT_NS * 2);
      chk("skew_no_frm_err", err_cnt - err_base, 32'd0);
      check_rx("skew");

      // Random bytes, random idle gaps and random rate within +/-1.5%.
      err_base = err_cnt;
      for (int k = 0; k < 16; k++) begin
         b = 8'($urandom_range(0, 255));
         gap = $urandom_range(0, 40);
         bit_ns = BIT_NS * (1.0 + (real'($urandom_range(0, 30)) - 15.0) / 1000.0);
         exp_q.push_back(b);
         drive_bits(mk_frame(b, 1'b1), 10, bit_ns);
         #(gap * 10);
      end
      #(BIT_NS * 2);
      chk("rand_no_frm_err", err_cnt - err_base, 32'd0);
      chk("rand_strobes_apart", both_cnt, 32'd0);
      check_rx("rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
